pll_reconf_ctrl: RTL and testbench
==================================

PLL_RECONF_CTRL -- requirements
Module: pll_reconf_ctrl

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: cycles mode_in must be unchanged before a reconfiguration starts.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: max cycles spent waiting for pll_locked after a reconfiguration.
REQ-003 Parameter ARESET_CYCLES, default 8: pll_areset pulse width on lock timeout.
REQ-004 Parameter MAX_RETRY, default 3: lock-timeout retries before the error state.
REQ-005 Port: clock, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port: reset_n, input, 1, synchronous active-low reset.
REQ-007 Port: mode_in, input, `MODE_SIZE, requested video mode.
REQ-008 Port: reconf_busy, input, 1, busy from the PLL reconfiguration core.
REQ-009 Port: pll_locked, input, 1, PLL lock indicator, already synchronised to clock.
REQ-010 Port: mode_req, output, `MODE_SIZE, mode driven to the PLL config ROM data input.
REQ-011 Port: write_from_rom, output, 1, one-cycle pulse loading the scan chain from ROM.
REQ-012 Port: reconfig, output, 1, one-cycle pulse applying the scan chain to the PLL.
REQ-013 Port: pll_areset, output, 1, PLL async-reset request.
REQ-014 Port: video_reset_n, output, 1, low holds the video pipeline in reset.
REQ-015 Port: cfg_done, output, 1, high while mode_req is configured and locked.
REQ-016 Port: cfg_error, output, 1, sticky retry-exhausted flag.

Function
REQ-017 States SHALL be: SETTLE, LOAD_PULSE, LOAD_WAIT, RECONF_PULSE, RECONF_WAIT, LOCK_WAIT, ARESET, RUN, ERROR.
REQ-018 SETTLE: stable counter increments while mode_in == previous-cycle mode_in, clears on any change; at STABLE_CYCLES-1 latch mode_req <= mode_in, clear retry count -> LOAD_PULSE.
REQ-019 LOAD_PULSE: write_from_rom = 1 for exactly one cycle -> LOAD_WAIT.
REQ-020 LOAD_WAIT / RECONF_WAIT: wait for reconf_busy high, or 4 cycles without it (guard counter), then wait reconf_busy low -> next state (RECONF_PULSE / LOCK_WAIT).
REQ-021 RECONF_PULSE: entered only with reconf_busy low; reconfig = 1 for exactly one cycle -> RECONF_WAIT.
REQ-022 LOCK_WAIT: 17-bit timeout counter cleared on entry; pll_locked high for 2 consecutive cycles -> RUN; counter reaching LOCK_TIMEOUT -> ARESET.
REQ-023 ARESET: pll_areset = 1 for ARESET_CYCLES cycles, retry count +1, then LOCK_WAIT; if retry count already == MAX_RETRY, go ERROR instead, pll_areset not asserted.
REQ-024 RUN: cfg_done = 1, video_reset_n = 1; mode_in != mode_req -> SETTLE; pll_locked low for 1 cycle -> LOCK_WAIT (no retry increment).
REQ-025 video_reset_n SHALL be 0 in every state except RUN; cfg_done registered, high only in RUN.
REQ-026 mode_in changes during LOAD_*/RECONF_* SHALL be ignored; reconfiguration completes with the latched mode_req, then re-evaluation in LOCK_WAIT/RUN.
REQ-027 In LOCK_WAIT, mode_in != mode_req SHALL abort to SETTLE (reconf_busy known low).
REQ-028 ERROR: cfg_error = 1 (sticky until reset); mode_in != mode_req -> SETTLE with cfg_error held.
REQ-029 write_from_rom and reconfig SHALL never be high in the same cycle, nor while reconf_busy is high.
REQ-030 All outputs SHALL be registered; latency mode_in change -> write_from_rom = STABLE_CYCLES + 1 cycles.

Reset
REQ-031 reset_n low at a clock edge SHALL force SETTLE, counters 0, mode_req 0, write_from_rom 0, reconfig 0, pll_areset 0, video_reset_n 0, cfg_done 0, cfg_error 0, regardless of state (including mid-busy).
REQ-032 After reset release the block SHALL configure the current mode_in even if it equals 0.

Verification
REQ-033 Reset, mode_in = `MODE_720p constant, busy model 10 cycles, lock 50 cycles after reconfig -> write_from_rom at cycle 17, one reconfig pulse, cfg_done and video_reset_n high 2 cycles after lock.
REQ-034 In RUN toggle mode_in 720p -> 1080p -> 720p within 10 cycles -> no write_from_rom until 16 stable cycles of 720p; mode_req stays 720p.
REQ-035 pll_locked never asserts, LOCK_TIMEOUT = 100 -> 3 pll_areset pulses of 8 cycles, then cfg_error = 1, video_reset_n = 0.
REQ-036 mode_in changed to `MODE_VGA during LOAD_WAIT -> reconfig still issued for old mode, then SETTLE, second full sequence with mode_req = `MODE_VGA.
REQ-037 reconf_busy never asserts -> LOAD_WAIT exits after 4 cycles; reconfig pulse follows; no deadlock.
REQ-038 reset_n low for 1 cycle during RECONF_WAIT -> all outputs at reset values next cycle, new sequence starts.

Source files
------------

// File: rtl/pll_reconf_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reconf_ctrl
//
// Purpose:
//   Sequences a PLL reconfiguration whenever the requested video mode changes
//   and has been stable long enough. It loads the scan chain from the config
//   ROM, applies it to the PLL and waits for lock. Lock timeouts are retried
//   with a PLL async reset, and the block parks in an error state once the
//   retries run out. The video pipeline is held in reset until the PLL is
//   configured and locked.
//
// Ports:
//   i_clock          - sole clock, all logic on its rising edge
//   i_reset_n        - synchronous active-low reset
//   i_mode_in        - requested video mode
//   i_reconf_busy    - busy flag from the PLL reconfiguration core
//   i_pll_locked     - PLL lock indicator, already synchronised to i_clock
//   o_mode_req       - mode presented to the PLL config ROM
//   o_write_from_rom - one-cycle pulse loading the scan chain from ROM
//   o_reconfig       - one-cycle pulse applying the scan chain to the PLL
//   o_pll_areset     - PLL async-reset request
//   o_video_reset_n  - low holds the video pipeline in reset
//   o_cfg_done       - high while o_mode_req is configured and locked
//   o_cfg_error      - sticky flag, retries exhausted
// -----------------------------------------------------------------------------

`ifndef MODE_SIZE
`define MODE_SIZE 3
`endif
`ifndef MODE_VGA
`define MODE_VGA 3'd0
`endif
`ifndef MODE_720p
`define MODE_720p 3'd2
`endif
`ifndef MODE_1080p
`define MODE_1080p 3'd3
`endif

module pll_reconf_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int ARESET_CYCLES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [`MODE_SIZE-1:0] i_mode_in,
    input  logic                  i_reconf_busy,
    input  logic                  i_pll_locked,
    output logic [`MODE_SIZE-1:0] o_mode_req,
    output logic                  o_write_from_rom,
    output logic                  o_reconfig,
    output logic                  o_pll_areset,
    output logic                  o_video_reset_n,
    output logic                  o_cfg_done,
    output logic                  o_cfg_error
);

    typedef enum logic [3:0] {
        ST_SETTLE,
        ST_LOAD_PULSE,
        ST_LOAD_WAIT,
        ST_RECONF_PULSE,
        ST_RECONF_WAIT,
        ST_LOCK_WAIT,
        ST_ARESET,
        ST_RUN,
        ST_ERROR
    } state_t;

    // One shared 17-bit counter serves as stable counter, busy guard, lock
    // timeout and areset width; it is cleared on every state change.
    localparam logic [16:0] STABLE_LAST  = 17'(STABLE_CYCLES - 1);
    localparam logic [16:0] GUARD_LAST   = 17'd3;
    localparam logic [16:0] TIMEOUT_LAST = 17'(LOCK_TIMEOUT);
    localparam logic [16:0] ARESET_LAST  = 17'(ARESET_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRY);

    state_t                  r_state;
    logic [16:0]             r_cnt;
    logic [`MODE_SIZE-1:0]   r_prev_mode;
    logic                    r_seen_busy;
    logic                    r_lock_prev;
    logic [7:0]              r_retry;
    logic [`MODE_SIZE-1:0]   r_mode_req;
    logic                    r_write_from_rom;
    logic                    r_reconfig;
    logic                    r_pll_areset;
    logic                    r_video_reset_n;
    logic                    r_cfg_done;
    logic                    r_cfg_error;

    state_t                  w_next_state;
    logic [16:0]             w_cnt_next;
    logic                    w_seen_busy_next;
    logic                    w_lock_prev_next;
    logic [7:0]              w_retry_next;
    logic                    w_latch_mode;
    logic                    w_wait_done_state;

    // Next-state logic. The two busy-wait states share one handshake: wait
    // for busy to rise (or give up after four idle cycles, in case the core
    // finished before we looked), then wait for busy to fall. Leaving only on
    // a sampled-low busy guarantees the following pulse never meets busy.
    always_comb begin
        w_next_state      = r_state;
        w_cnt_next        = r_cnt;
        w_seen_busy_next  = r_seen_busy;
        w_lock_prev_next  = 1'b0;
        w_retry_next      = r_retry;
        w_latch_mode      = 1'b0;
        w_wait_done_state = 1'b0;

        case (r_state)
            ST_SETTLE: begin
                if (i_mode_in != r_prev_mode) begin
                    w_cnt_next = 17'd0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = ST_LOAD_PULSE;
                    w_latch_mode = 1'b1;
                    w_retry_next = 8'd0;
                end else begin
                    w_cnt_next = r_cnt + 17'd1;
                end
            end

            ST_LOAD_PULSE: begin
                w_next_state = ST_LOAD_WAIT;
            end

            ST_LOAD_WAIT, ST_RECONF_WAIT: begin
                if (!r_seen_busy) begin
                    if (i_reconf_busy) begin
                        w_seen_busy_next = 1'b1;
                    end else if (r_cnt == GUARD_LAST) begin
                        w_wait_done_state = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 17'd1;
                    end
                end else if (!i_reconf_busy) begin
                    w_wait_done_state = 1'b1;
                end
                if (w_wait_done_state) begin
                    w_next_state = (r_state == ST_LOAD_WAIT) ? ST_RECONF_PULSE
                                                             : ST_LOCK_WAIT;
                end
            end

            ST_RECONF_PULSE: begin
                w_next_state = ST_RECONF_WAIT;
            end

            // A mode change here is safe to act on at once because the
            // reconfiguration core has already gone idle.
            ST_LOCK_WAIT: begin
                w_lock_prev_next = i_pll_locked;
                if (i_mode_in != r_mode_req) begin
                    w_next_state = ST_SETTLE;
                end else if (i_pll_locked && r_lock_prev) begin
                    w_next_state = ST_RUN;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_next_state = (r_retry == RETRY_MAX) ? ST_ERROR : ST_ARESET;
                end else begin
                    w_cnt_next = r_cnt + 17'd1;
                end
            end

            ST_ARESET: begin
                if (r_cnt == ARESET_LAST) begin
                    w_next_state = ST_LOCK_WAIT;
                    w_retry_next = r_retry + 8'd1;
                end else begin
                    w_cnt_next = r_cnt + 17'd1;
                end
            end

            ST_RUN: begin
                if (i_mode_in != r_mode_req) begin
                    w_next_state = ST_SETTLE;
                end else if (!i_pll_locked) begin
                    w_next_state = ST_LOCK_WAIT;
                end
            end

            ST_ERROR: begin
                if (i_mode_in != r_mode_req) begin
                    w_next_state = ST_SETTLE;
                end
            end

            default: begin
                w_next_state = ST_SETTLE;
            end
        endcase
    end

    // State and datapath registers. Outputs are decoded from the next state
    // so each one is a flop that lines up with the state it belongs to.
    // The previous-mode sampler loads the live input during reset, so that
    // reset release counts as the start of a stable window.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state          <= ST_SETTLE;
            r_cnt            <= 17'd0;
            r_prev_mode      <= i_mode_in;
            r_seen_busy      <= 1'b0;
            r_lock_prev      <= 1'b0;
            r_retry          <= 8'd0;
            r_mode_req       <= '0;
            r_write_from_rom <= 1'b0;
            r_reconfig       <= 1'b0;
            r_pll_areset     <= 1'b0;
            r_video_reset_n  <= 1'b0;
            r_cfg_done       <= 1'b0;
            r_cfg_error      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_prev_mode <= i_mode_in;
            r_retry     <= w_retry_next;
            if (w_next_state != r_state) begin
                r_cnt       <= 17'd0;
                r_seen_busy <= 1'b0;
                r_lock_prev <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_next;
                r_seen_busy <= w_seen_busy_next;
                r_lock_prev <= w_lock_prev_next;
            end
            if (w_latch_mode) begin
                r_mode_req <= i_mode_in;
            end
            r_write_from_rom <= (w_next_state == ST_LOAD_PULSE);
            r_reconfig       <= (w_next_state == ST_RECONF_PULSE);
            r_pll_areset     <= (w_next_state == ST_ARESET);
            r_video_reset_n  <= (w_next_state == ST_RUN);
            r_cfg_done       <= (w_next_state == ST_RUN);
            r_cfg_error      <= r_cfg_error | (w_next_state == ST_ERROR);
        end
    end

    assign o_mode_req       = r_mode_req;
    assign o_write_from_rom = r_write_from_rom;
    assign o_reconfig       = r_reconfig;
    assign o_pll_areset     = r_pll_areset;
    assign o_video_reset_n  = r_video_reset_n;
    assign o_cfg_done       = r_cfg_done;
    assign o_cfg_error      = r_cfg_error;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reconf_ctrl
//
// Purpose:
//   Self-checking bench for pll_reconf_ctrl. Directed scenarios push the
//   expected output events (ROM load, reconfig, done, areset, error) into a
//   queue; a monitor on the falling edge pops and compares each event the DUT
//   produces. Behavioural models of the reconfiguration core (busy) and the
//   PLL (lock) react to the DUT strobes.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------

`ifndef MODE_SIZE
`define MODE_SIZE 3
`endif
`ifndef MODE_VGA
`define MODE_VGA 3'd0
`endif
`ifndef MODE_720p
`define MODE_720p 3'd2
`endif
`ifndef MODE_1080p
`define MODE_1080p 3'd3
`endif

module tb_pll_reconf_ctrl;

    localparam int STABLE  = 16;
    localparam int LOCK_TO = 100;
    localparam int AR_CYC  = 8;
    localparam int RETRIES = 3;

    localparam logic [`MODE_SIZE-1:0] M_VGA   = `MODE_VGA;
    localparam logic [`MODE_SIZE-1:0] M_720   = `MODE_720p;
    localparam logic [`MODE_SIZE-1:0] M_1080  = `MODE_1080p;

    typedef enum int {EV_WFR, EV_RCF, EV_DONE, EV_ARST, EV_ERR} evKind_t;

    typedef struct {
        evKind_t               kind;
        logic [`MODE_SIZE-1:0] mode;
        int                    atCyc;
    } expItem_t;

    expItem_t expQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int relCyc = 0;
    int changeCyc = 0;
    int busyLen = 10;
    int busyCnt = 0;
    int lockDelay = 50;
    int lockCnt = 0;
    int lockRiseCyc = 0;
    int arstWidth = 0;
    logic prevDone = 1'b0;
    logic prevArst = 1'b0;
    logic prevErr = 1'b0;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [`MODE_SIZE-1:0] modeIn = `MODE_720p;
    logic                  reconfBusy = 1'b0;
    logic                  pllLocked = 1'b0;
    logic [`MODE_SIZE-1:0] modeReq;
    logic                  writeFromRom;
    logic                  reconfig;
    logic                  pllAreset;
    logic                  videoResetN;
    logic                  cfgDone;
    logic                  cfgError;

    pll_reconf_ctrl #(
        .STABLE_CYCLES(STABLE),
        .LOCK_TIMEOUT (LOCK_TO),
        .ARESET_CYCLES(AR_CYC),
        .MAX_RETRY    (RETRIES)
    ) dut (
        .i_clock         (clock),
        .i_reset_n       (reset_n),
        .i_mode_in       (modeIn),
        .i_reconf_busy   (reconfBusy),
        .i_pll_locked    (pllLocked),
        .o_mode_req      (modeReq),
        .o_write_from_rom(writeFromRom),
        .o_reconfig      (reconfig),
        .o_pll_areset    (pllAreset),
        .o_video_reset_n (videoResetN),
        .o_cfg_done      (cfgDone),
        .o_cfg_error     (cfgError)
    );

    // Free-running clock and a cycle counter used to timestamp events.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input evKind_t kind, input logic [`MODE_SIZE-1:0] mode, input int atCyc);
        expItem_t e;
        e.kind  = kind;
        e.mode  = mode;
        e.atCyc = atCyc;
        expQ.push_back(e);
    endtask

    // Pops the oldest expected event and compares it with what the DUT shows.
    task automatic scoreEvent(input evKind_t kind);
        expItem_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_event_kind", int'(kind), -1);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", int'(kind), int'(e.kind));
            checkOutput("event_mode_req", int'(modeReq), int'(e.mode));
            if (e.atCyc >= 0) begin
                checkOutput("event_cycle", cyc, e.atCyc);
            end
        end
    endtask

    // Monitor plus busy/lock models, all on the falling edge so outputs are
    // stable. The monitor looks at the outputs before the models react.
    always @(negedge clock) begin
        if (writeFromRom || reconfig) begin
            checkOutput("strobe_overlap_or_busy", int'({writeFromRom & reconfig, reconfBusy}), 0);
        end
        if (writeFromRom) scoreEvent(EV_WFR);
        if (reconfig) scoreEvent(EV_RCF);
        if (cfgDone && !prevDone) begin
            scoreEvent(EV_DONE);
            checkOutput("done_video_reset_n", int'(videoResetN), 1);
            checkOutput("done_cycles_after_lock", cyc - lockRiseCyc, 2);
        end
        if (pllAreset && !prevArst) scoreEvent(EV_ARST);
        if (pllAreset) begin
            arstWidth++;
        end else if (prevArst) begin
            checkOutput("areset_width", arstWidth, AR_CYC);
            arstWidth = 0;
        end
        if (cfgError && !prevErr) begin
            scoreEvent(EV_ERR);
            checkOutput("error_video_reset_n", int'(videoResetN), 0);
        end
        prevDone = cfgDone;
        prevArst = pllAreset;
        prevErr  = cfgError;

        if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) reconfBusy = 1'b0;
        end
        if ((writeFromRom || reconfig) && busyLen > 0) begin
            reconfBusy = 1'b1;
            busyCnt    = busyLen;
        end

        if (reconfig) begin
            pllLocked = 1'b0;
            lockCnt   = lockDelay;
        end else if (lockCnt > 0) begin
            lockCnt--;
            if (lockCnt == 0) begin
                pllLocked   = 1'b1;
                lockRiseCyc = cyc;
            end
        end
    end

    // Holds reset for two edges, checks every output is at its reset value,
    // then releases; relCyc marks the last edge that saw reset.
    task automatic applyReset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_outputs",
                    int'({modeReq, writeFromRom, reconfig, pllAreset, videoResetN, cfgDone, cfgError}), 0);
        reset_n = 1'b1;
        relCyc  = cyc;
    endtask

    task automatic applyStimulus(input logic [`MODE_SIZE-1:0] mode);
        @(negedge clock);
        modeIn    = mode;
        changeCyc = cyc;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && expQ.size() != 0; i++) @(negedge clock);
        checkOutput("queue_drained_remaining", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic waitStrobe(input bit wantReconfig, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            seen = wantReconfig ? reconfig : writeFromRom;
        end
        checkOutput("strobe_seen", int'(seen), 1);
    endtask

    initial begin
        // Power-up with a constant 720p request: ROM load in the 17th cycle
        // after release, one reconfig, done two cycles after lock.
        busyLen   = 10;
        lockDelay = 50;
        modeIn    = M_720;
        applyReset();
        pushExp(EV_WFR, M_720, relCyc + STABLE);
        pushExp(EV_RCF, M_720, -1);
        pushExp(EV_DONE, M_720, -1);
        waitDrain(300);

        // Glitchy request 720p -> 1080p -> 720p: nothing is loaded until 720p
        // has been stable for the full window, and mode_req never leaves 720p.
        applyStimulus(M_1080);
        repeat (4) @(negedge clock);
        applyStimulus(M_720);
        begin
            int c2;
            c2 = changeCyc;
            repeat (8) @(negedge clock);
            checkOutput("toggle_mode_req", int'(modeReq), int'(M_720));
            checkOutput("toggle_video_reset_n", int'(videoResetN), 0);
            pushExp(EV_WFR, M_720, c2 + STABLE + 1);
        end
        pushExp(EV_RCF, M_720, -1);
        pushExp(EV_DONE, M_720, -1);
        waitDrain(300);

        // Change to VGA while the ROM load is in flight: the 1080p reconfig
        // still goes out, then a second full sequence for VGA.
        applyStimulus(M_1080);
        pushExp(EV_WFR, M_1080, changeCyc + STABLE + 1);
        pushExp(EV_RCF, M_1080, -1);
        pushExp(EV_WFR, M_VGA, -1);
        pushExp(EV_RCF, M_VGA, -1);
        pushExp(EV_DONE, M_VGA, -1);
        waitStrobe(1'b0, 40);
        repeat (2) @(negedge clock);
        modeIn = M_VGA;
        waitDrain(400);

        // PLL never locks: three areset pulses, then the error state.
        lockDelay = -1;
        applyStimulus(M_720);
        pushExp(EV_WFR, M_720, changeCyc + STABLE + 1);
        pushExp(EV_RCF, M_720, -1);
        pushExp(EV_ARST, M_720, -1);
        pushExp(EV_ARST, M_720, -1);
        pushExp(EV_ARST, M_720, -1);
        pushExp(EV_ERR, M_720, -1);
        waitDrain(1000);
        repeat (2) @(negedge clock);
        checkOutput("error_flag", int'(cfgError), 1);
        checkOutput("error_video_reset_n_held", int'(videoResetN), 0);

        // A new request leaves the error state; the error flag stays set.
        lockDelay = 50;
        applyStimulus(M_1080);
        pushExp(EV_WFR, M_1080, changeCyc + STABLE + 1);
        pushExp(EV_RCF, M_1080, -1);
        pushExp(EV_DONE, M_1080, -1);
        waitDrain(400);
        checkOutput("error_sticky", int'(cfgError), 1);

        // Reset with mode 0 and a core that never raises busy: mode 0 is
        // still configured and each busy wait gives up after four cycles.
        busyLen = 0;
        modeIn  = M_VGA;
        applyReset();
        pushExp(EV_WFR, M_VGA, relCyc + STABLE);
        pushExp(EV_RCF, M_VGA, relCyc + STABLE + 5);
        pushExp(EV_DONE, M_VGA, -1);
        waitDrain(300);

        // One-cycle reset while waiting on busy after reconfig: outputs clear
        // on the next cycle and a fresh sequence follows.
        busyLen = 10;
        applyStimulus(M_720);
        pushExp(EV_WFR, M_720, changeCyc + STABLE + 1);
        pushExp(EV_RCF, M_720, -1);
        waitStrobe(1'b1, 80);
        waitDrain(10);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("midbusy_reset_outputs",
                    int'({modeReq, writeFromRom, reconfig, pllAreset, videoResetN, cfgDone, cfgError}), 0);
        reset_n = 1'b1;
        relCyc  = cyc;
        pushExp(EV_WFR, M_720, relCyc + STABLE);
        pushExp(EV_RCF, M_720, -1);
        pushExp(EV_DONE, M_720, -1);
        waitDrain(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always ends even if the sequencing stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout expected finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
